// File: rtl/pipe_pkg.sv
// Shared definitions for the fetch/decode pipeline boundary: the canonical
// IF->DE payload layout and the bubble instruction used when a stage is empty.
package pipe_pkg;

    localparam int unsigned PIPE_DATA_WIDTH   = 32;

    // addi x0, x0, 0 -- architecturally a no-op, safe to feed the decoder
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    // Canonical IF->DE beat; the stage register rebuilds the same layout
    // at its own DATA_WIDTH so narrower/wider cores keep the field order.
    typedef struct packed {
        logic [PIPE_DATA_WIDTH-1:0] pc;
        logic [PIPE_DATA_WIDTH-1:0] pcn;
        logic [PIPE_DATA_WIDTH-1:0] instr;
    } if_de_payload_t;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: a valid flag plus a payload register. The owner decides
// when to load or clear; clear only drops the valid flag, the payload is kept.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 3 * PIPE_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    // Valid flag: clear wins over load so a kill can never be overridden
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
        end
    end

    // Payload only moves when a beat is actually written into this slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/de_pipe_reg.sv
// IF->DE stage register with valid/ready handshake, flush, and an optional
// skid slot that makes up_ready a pure register output. Only steering lives
// here; storage is in the pipe_slot instances.
module de_pipe_reg
    import pipe_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = PIPE_DATA_WIDTH,
    parameter bit                    SKID_EN    = 1'b1,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(NOP_INSTR_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  up_valid,
    output logic                  up_ready,
    input  logic [DATA_WIDTH-1:0] up_pc,
    input  logic [DATA_WIDTH-1:0] up_pcn,
    input  logic [DATA_WIDTH-1:0] up_instr,
    output logic                  dn_valid,
    input  logic                  dn_ready,
    output logic [DATA_WIDTH-1:0] dn_pc,
    output logic [DATA_WIDTH-1:0] dn_pcn,
    output logic [DATA_WIDTH-1:0] dn_instr
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] pcn;
        logic [DATA_WIDTH-1:0] instr;
    } payload_t;

    localparam int unsigned PW = $bits(payload_t);

    payload_t upPayload;
    payload_t mainPayload;
    payload_t mainDataIn;
    logic     mainValid;
    logic     mainLoad;
    logic     mainClear;
    logic     upAccept;
    logic     dnConsume;

    assign upPayload = '{pc: up_pc, pcn: up_pcn, instr: up_instr};
    assign upAccept  = up_valid & up_ready;
    assign dnConsume = mainValid & dn_ready;

    generate
        if (SKID_EN) begin : g_skid
            payload_t skidPayload;
            logic     skidValid;
            logic     skidToMain;
            logic     upToMain;
            logic     skidLoad;
            logic     skidClear;

            // Skid drains first to keep FIFO order; while skid is full
            // up_ready is low, so skid and upstream never compete for main.
            assign skidToMain = dnConsume & skidValid;
            assign upToMain   = upAccept & (~mainValid | dnConsume);
            assign skidLoad   = ~flush & upAccept & mainValid & ~dnConsume;
            assign skidClear  = flush | skidToMain;
            assign mainLoad   = ~flush & (skidToMain | upToMain);
            assign mainClear  = flush | (dnConsume & ~(skidToMain | upToMain));
            assign mainDataIn = skidValid ? skidPayload : upPayload;
            assign up_ready   = ~skidValid;

            pipe_slot #(.WIDTH(PW)) u_skid_slot (
                .clk     (clk),
                .rst_n   (rst_n),
                .load_i  (skidLoad),
                .clear_i (skidClear),
                .data_i  (upPayload),
                .valid_o (skidValid),
                .data_o  (skidPayload)
            );
        end else begin : g_noskid
            // Single slot: accept whenever main is empty or being drained
            assign up_ready   = dn_ready | ~mainValid;
            assign mainLoad   = ~flush & upAccept;
            assign mainClear  = flush | (dnConsume & ~upAccept);
            assign mainDataIn = upPayload;
        end
    endgenerate

    pipe_slot #(.WIDTH(PW)) u_main_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (mainLoad),
        .clear_i (mainClear),
        .data_i  (mainDataIn),
        .valid_o (mainValid),
        .data_o  (mainPayload)
    );

    // An empty stage hands the decoder a bubble instead of stale bits
    assign dn_valid = mainValid;
    assign dn_pc    = mainPayload.pc;
    assign dn_pcn   = mainPayload.pcn;
    assign dn_instr = mainValid ? mainPayload.instr : NOP_INSTR;

endmodule

// File: tb/tb_de_pipe_reg.sv
// Directed bench for de_pipe_reg: a skid instance checked against a
// scoreboard of accepted beats, plus a single-slot instance checked directly.
module tb_de_pipe_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        up_valid;
    logic        up_valid0;
    logic [31:0] up_pc;
    logic [31:0] up_pcn;
    logic [31:0] up_instr;
    logic        dn_ready;

    logic        s_up_ready, s_dn_valid;
    logic [31:0] s_dn_pc, s_dn_pcn, s_dn_instr;
    logic        n_up_ready, n_dn_valid;
    logic [31:0] n_dn_pc, n_dn_pcn, n_dn_instr;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pcn;
        logic [31:0] instr;
    } beat_t;

    beat_t sb[$];
    int    nChecks = 0;
    int    nPass   = 0;

    always #5 clk = ~clk;

    de_pipe_reg #(.DATA_WIDTH(32), .SKID_EN(1'b1), .NOP_INSTR(NOP)) u_skid (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .up_valid(up_valid), .up_ready(s_up_ready),
        .up_pc(up_pc), .up_pcn(up_pcn), .up_instr(up_instr),
        .dn_valid(s_dn_valid), .dn_ready(dn_ready),
        .dn_pc(s_dn_pc), .dn_pcn(s_dn_pcn), .dn_instr(s_dn_instr)
    );

    de_pipe_reg #(.DATA_WIDTH(32), .SKID_EN(1'b0), .NOP_INSTR(NOP)) u_noskid (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .up_valid(up_valid0), .up_ready(n_up_ready),
        .up_pc(up_pc), .up_pcn(up_pcn), .up_instr(up_instr),
        .dn_valid(n_dn_valid), .dn_ready(dn_ready),
        .dn_pc(n_dn_pc), .dn_pcn(n_dn_pcn), .dn_instr(n_dn_instr)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic dr, input logic fl);
        up_valid = v;
        up_pc    = pc;
        up_pcn   = pc + 32'd4;
        up_instr = pc ^ 32'hA5A5_0000;
        dn_ready = dr;
        flush    = fl;
    endtask

    // Drive point: one time unit after each rising edge
    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int budget;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        budget = 20;
        while ((sb.size() != 0 || s_dn_valid) && budget > 0) begin
            waitCycle();
            budget--;
        end
        checkOutput("drain_empty", 32'(sb.size()), 32'd0);
        checkOutput("drain_dn_valid", {31'd0, s_dn_valid}, 32'd0);
    endtask

    // Scoreboard: inputs are stable at the falling edge, so what is seen here
    // is exactly what the next rising edge will transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (s_dn_valid && dn_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_underflow", 32'd0, 32'd1);
                end else begin
                    beat_t exp;
                    exp = sb.pop_front();
                    checkOutput("sb_pc", s_dn_pc, exp.pc);
                    checkOutput("sb_pcn", s_dn_pcn, exp.pcn);
                    checkOutput("sb_instr", s_dn_instr, exp.instr);
                end
            end
            if (flush) begin
                sb.delete();
            end else if (up_valid && s_up_ready) begin
                sb.push_back('{pc: up_pc, pcn: up_pcn, instr: up_instr});
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset held with a beat offered
        rst_n     = 1'b0;
        up_valid0 = 1'b1;
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b0);
        #18;
        checkOutput("rst_dn_valid", {31'd0, s_dn_valid}, 32'd0);
        checkOutput("rst_dn_instr", s_dn_instr, NOP);
        checkOutput("rst_dn_pc", s_dn_pc, 32'd0);
        checkOutput("rst_up_ready", {31'd0, s_up_ready}, 32'd1);
        checkOutput("rst0_dn_valid", {31'd0, n_dn_valid}, 32'd0);
        checkOutput("rst0_dn_instr", n_dn_instr, NOP);
        checkOutput("rst0_up_ready", {31'd0, n_up_ready}, 32'd1);
        #1;
        rst_n     = 1'b1;
        up_valid0 = 1'b0;

        // First beat after release, then streaming
        waitCycle();
        checkOutput("lat_dn_valid", {31'd0, s_dn_valid}, 32'd1);
        checkOutput("lat_dn_pc", s_dn_pc, 32'h100);
        checkOutput("lat_dn_pcn", s_dn_pcn, 32'h104);
        applyStimulus(1'b1, 32'h104, 1'b1, 1'b0);
        waitCycle();
        checkOutput("stream_pc1", s_dn_pc, 32'h104);
        applyStimulus(1'b1, 32'h108, 1'b1, 1'b0);
        waitCycle();
        checkOutput("stream_pc2", s_dn_pc, 32'h108);

        // Skid stall: one more beat absorbed, then up_ready drops
        applyStimulus(1'b1, 32'h10C, 1'b0, 1'b0);
        waitCycle();
        applyStimulus(1'b1, 32'h110, 1'b0, 1'b0);
        checkOutput("stall_up_ready0", {31'd0, s_up_ready}, 32'd0);
        checkOutput("stall_dn_pc0", s_dn_pc, 32'h108);
        for (int i = 1; i < 4; i++) begin
            waitCycle();
            checkOutput("stall_up_ready", {31'd0, s_up_ready}, 32'd0);
            checkOutput("stall_dn_pc", s_dn_pc, 32'h108);
        end
        dn_ready = 1'b1;
        waitCycle();
        checkOutput("unstall_up_ready", {31'd0, s_up_ready}, 32'd1);
        checkOutput("unstall_dn_pc", s_dn_pc, 32'h10C);
        waitCycle();
        applyStimulus(1'b1, 32'h114, 1'b1, 1'b0);
        waitCycle();
        drain();

        // Flush with both slots full; 0x200 must never appear
        applyStimulus(1'b1, 32'h180, 1'b0, 1'b0);
        waitCycle();
        applyStimulus(1'b1, 32'h184, 1'b0, 1'b0);
        waitCycle();
        checkOutput("full_up_ready", {31'd0, s_up_ready}, 32'd0);
        checkOutput("full_dn_pc", s_dn_pc, 32'h180);
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b1);
        waitCycle();
        checkOutput("flush_dn_valid", {31'd0, s_dn_valid}, 32'd0);
        checkOutput("flush_dn_instr", s_dn_instr, NOP);
        checkOutput("flush_up_ready", {31'd0, s_up_ready}, 32'd1);
        applyStimulus(1'b1, 32'h300, 1'b1, 1'b0);
        waitCycle();
        checkOutput("post_flush_valid", {31'd0, s_dn_valid}, 32'd1);
        checkOutput("post_flush_pc", s_dn_pc, 32'h300);

        // Flush coinciding with a consume and an accepted beat
        applyStimulus(1'b1, 32'h310, 1'b1, 1'b0);
        waitCycle();
        applyStimulus(1'b1, 32'h320, 1'b1, 1'b1);
        waitCycle();
        checkOutput("flush_consume_valid", {31'd0, s_dn_valid}, 32'd0);
        drain();

        // Asynchronous reset in the middle of a stall with both slots full
        applyStimulus(1'b1, 32'h500, 1'b0, 1'b0);
        waitCycle();
        applyStimulus(1'b1, 32'h504, 1'b0, 1'b0);
        waitCycle();
        checkOutput("pre_rst_up_ready", {31'd0, s_up_ready}, 32'd0);
        up_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        checkOutput("arst_dn_valid", {31'd0, s_dn_valid}, 32'd0);
        checkOutput("arst_up_ready", {31'd0, s_up_ready}, 32'd1);
        rst_n = 1'b1;
        waitCycle();
        checkOutput("arst_after_valid", {31'd0, s_dn_valid}, 32'd0);
        checkOutput("arst_after_ready", {31'd0, s_up_ready}, 32'd1);

        // Single-slot instance: combinational ready during a stall
        up_valid0 = 1'b1;
        applyStimulus(1'b0, 32'h400, 1'b1, 1'b0);
        waitCycle();
        checkOutput("ns_valid", {31'd0, n_dn_valid}, 32'd1);
        checkOutput("ns_pc0", n_dn_pc, 32'h400);
        checkOutput("ns_pcn0", n_dn_pcn, 32'h404);
        applyStimulus(1'b0, 32'h404, 1'b1, 1'b0);
        waitCycle();
        checkOutput("ns_pc1", n_dn_pc, 32'h404);
        applyStimulus(1'b0, 32'h408, 1'b0, 1'b0);
        #1;
        checkOutput("ns_ready_fall", {31'd0, n_up_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            waitCycle();
            checkOutput("ns_stall_pc", n_dn_pc, 32'h404);
            checkOutput("ns_stall_ready", {31'd0, n_up_ready}, 32'd0);
        end
        dn_ready = 1'b1;
        #1;
        checkOutput("ns_ready_rise", {31'd0, n_up_ready}, 32'd1);
        waitCycle();
        checkOutput("ns_pc2", n_dn_pc, 32'h408);
        up_valid0 = 1'b0;
        waitCycle();
        checkOutput("ns_empty_valid", {31'd0, n_dn_valid}, 32'd0);
        checkOutput("ns_empty_instr", n_dn_instr, NOP);
        checkOutput("ns_empty_ready", {31'd0, n_up_ready}, 32'd1);

        waitCycle();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
